// File: rtl/nib_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nib_pkg
// Brief    : Shared state encoding and defaults for the nibble TX controller.
// Revision : 1.0 - initial release
// ============================================================================
package nib_pkg;

    localparam int c_TIMEOUT_CYCLES_DFLT = 1023;
    localparam int c_SYNC_STAGES_DFLT    = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HI_REQ = 3'd1,
        ST_HI_REL = 3'd2,
        ST_LO_REQ = 3'd3,
        ST_LO_REL = 3'd4
    } nib_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
// Module   : sync_bit
// Brief    : Multi-flop synchronizer for a single asynchronous bit.
// Revision : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/nib_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nib_tx_ctrl
// Brief    : Sends a byte as two nibbles over a 4-phase strobe/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module nib_tx_ctrl
    import nib_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DFLT,
    parameter int SYNC_STAGES    = c_SYNC_STAGES_DFLT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ack,
    output logic       strobe,
    output logic [3:0] nout,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_DWELL    = c_CNT_W'(SYNC_STAGES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES);

    nib_state_e         state_q;
    logic [7:0]         hold_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;
    logic               strobe_q;
    logic [3:0]         nout_q;
    logic               done_q;
    logic               timeout_err_q;
    logic               ack_s;
    logic               ack_want;
    logic               advance;
    logic               abort;

    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (ack),
        .q_o     (ack_s)
    );

    always_comb begin
        ack_want = 1'b0;
        case (state_q)
            ST_HI_REQ, ST_LO_REQ: ack_want = 1'b1;
            default:              ack_want = 1'b0;
        endcase
    end

    // Each wait state dwells at least SYNC_STAGES cycles so an ack that is
    // already at the awaited level cannot collapse a handshake phase.
    assign cnt_d   = cnt_q + c_CNT_W'(1);
    assign busy    = (state_q != ST_IDLE);
    assign advance = busy && (cnt_q >= c_DWELL) && (ack_s == ack_want);
    assign abort   = busy && !advance && (cnt_d == c_CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            hold_q        <= '0;
            cnt_q         <= '0;
            strobe_q      <= 1'b0;
            nout_q        <= '0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            if (abort) begin
                state_q       <= ST_IDLE;
                hold_q        <= '0;
                cnt_q         <= '0;
                strobe_q      <= 1'b0;
                nout_q        <= '0;
                timeout_err_q <= 1'b1;
            end else if (advance) begin
                cnt_q <= '0;
                case (state_q)
                    ST_HI_REQ: begin
                        state_q  <= ST_HI_REL;
                        strobe_q <= 1'b0;
                    end
                    ST_HI_REL: begin
                        state_q  <= ST_LO_REQ;
                        hold_q   <= {hold_q[3:0], 4'h0};
                        nout_q   <= hold_q[3:0];
                        strobe_q <= 1'b1;
                    end
                    ST_LO_REQ: begin
                        state_q  <= ST_LO_REL;
                        strobe_q <= 1'b0;
                    end
                    ST_LO_REL: begin
                        state_q <= ST_IDLE;
                        hold_q  <= '0;
                        nout_q  <= '0;
                        done_q  <= 1'b1;
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        strobe_q <= 1'b0;
                        nout_q   <= '0;
                    end
                endcase
            end else if (state_q == ST_IDLE) begin
                cnt_q <= '0;
                if (tx_valid) begin
                    state_q  <= ST_HI_REQ;
                    hold_q   <= tx_data;
                    nout_q   <= tx_data[7:4];
                    strobe_q <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign tx_ready    = (state_q == ST_IDLE);
    assign strobe      = strobe_q;
    assign nout        = nout_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire
